// File: rtl/uop_prog_sequencer_pkg.sv
// Shared definitions for the curve point engine microprogram sequencer.
// Contents: field widths, opcode / register / exec-condition encodings,
// program ids, sequencer state type, and small helpers to build uop words
// and to evaluate an exec condition against the datapath cond bit.
// uop layout (20 bits): [19:16] opcode, [15:12] dst, [11:8] src_a,
//                       [7:4] src_b, [3:2] reserved, [1:0] exec.
package uop_prog_sequencer_pkg;

  localparam int UOP_W_DEF    = 20;
  localparam int OPCODE_W_DEF = 4;
  localparam int EXEC_W_DEF   = 2;
  localparam int PC_W_DEF     = 6;
  localparam int PROG_W_DEF   = 2;
  localparam int REG_W        = 4;

  localparam logic [3:0] OPCODE_NOP = 4'h0;
  localparam logic [3:0] OPCODE_MOV = 4'h1;
  localparam logic [3:0] OPCODE_ADD = 4'h2;
  localparam logic [3:0] OPCODE_SUB = 4'h3;
  localparam logic [3:0] OPCODE_MUL = 4'h4;
  localparam logic [3:0] OPCODE_SQR = 4'h5;
  localparam logic [3:0] OPCODE_RDY = 4'hF;

  localparam logic [3:0] UOP_DST_RX = 4'h1;
  localparam logic [3:0] UOP_DST_RY = 4'h2;
  localparam logic [3:0] UOP_DST_RZ = 4'h3;
  localparam logic [3:0] UOP_DST_T0 = 4'h4;
  localparam logic [3:0] UOP_DST_T1 = 4'h5;
  localparam logic [3:0] UOP_DST_T2 = 4'h6;

  localparam logic [3:0] UOP_SRC_ZERO = 4'h0;
  localparam logic [3:0] UOP_SRC_GX   = 4'h1;
  localparam logic [3:0] UOP_SRC_GY   = 4'h2;
  localparam logic [3:0] UOP_SRC_ONE  = 4'h3;
  localparam logic [3:0] UOP_SRC_T0   = 4'h4;
  localparam logic [3:0] UOP_SRC_T1   = 4'h5;

  localparam logic [1:0] UOP_EXEC_ALWAYS = 2'b00;
  localparam logic [1:0] UOP_EXEC_IF_CLR = 2'b01;
  localparam logic [1:0] UOP_EXEC_IF_SET = 2'b10;
  localparam logic [1:0] UOP_EXEC_RSVD   = 2'b11;

  localparam logic [1:0] PROG_INIT  = 2'd0;  // load base point into RX/RY/RZ
  localparam logic [1:0] PROG_COND  = 2'd1;  // conditional select sequence
  localparam logic [1:0] PROG_EMPTY = 2'd2;  // no work, immediate RDY
  localparam logic [1:0] PROG_LOOP  = 2'd3;  // 64 accumulate steps, no RDY

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_ISSUE  = 3'd4
  } seq_state_e;

  function automatic logic [UOP_W_DEF-1:0] mk_uop(
    input logic [3:0] op,
    input logic [3:0] dst,
    input logic [3:0] src_a,
    input logic [3:0] src_b,
    input logic [1:0] exec
  );
    return {op, dst, src_a, src_b, 2'b00, exec};
  endfunction

  // Reserved exec code never issues.
  function automatic logic exec_pass(input logic [1:0] exec, input logic cond);
    logic pass;
    case (exec)
      UOP_EXEC_ALWAYS: pass = 1'b1;
      UOP_EXEC_IF_CLR: pass = ~cond;
      UOP_EXEC_IF_SET: pass = cond;
      default:         pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/uop_prog_sequencer_rom.sv
// Registered case-ROM holding every microprogram of the sequencer.
// Ports: clk (read clock), addr ({prog, pc}), data (word, valid one cycle
// after addr). Addresses not listed return an ALWAYS RDY word.
module uop_prog_sequencer_rom
  import uop_prog_sequencer_pkg::*;
#(
  parameter int UOP_W  = UOP_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int PROG_W = PROG_W_DEF
) (
  input  logic                     clk,
  input  logic [PROG_W+PC_W-1:0]   addr,
  output logic [UOP_W-1:0]         data
);

  localparam logic [UOP_W-1:0] WORD_RDY =
    mk_uop(OPCODE_RDY, 4'h0, 4'h0, 4'h0, UOP_EXEC_ALWAYS);

  logic [PROG_W-1:0] prog_s;
  logic [PC_W-1:0]   pc_s;

  assign prog_s = addr[PC_W +: PROG_W];
  assign pc_s   = addr[PC_W-1:0];

  // Synchronous ROM read: one word per cycle at {prog, pc}.
  always_ff @(posedge clk) begin
    case (prog_s)
      PROG_INIT: begin
        case (pc_s)
          PC_W'(0): data <= mk_uop(OPCODE_MOV, UOP_DST_RX, UOP_SRC_GX,  UOP_SRC_ZERO, UOP_EXEC_ALWAYS);
          PC_W'(1): data <= mk_uop(OPCODE_MOV, UOP_DST_RY, UOP_SRC_GY,  UOP_SRC_ZERO, UOP_EXEC_ALWAYS);
          PC_W'(2): data <= mk_uop(OPCODE_MOV, UOP_DST_RZ, UOP_SRC_ONE, UOP_SRC_ZERO, UOP_EXEC_ALWAYS);
          default:  data <= WORD_RDY;
        endcase
      end
      PROG_COND: begin
        case (pc_s)
          PC_W'(0): data <= mk_uop(OPCODE_MOV, UOP_DST_T0, UOP_SRC_GX, UOP_SRC_ZERO, UOP_EXEC_IF_CLR);
          PC_W'(1): data <= mk_uop(OPCODE_MOV, UOP_DST_T1, UOP_SRC_GY, UOP_SRC_ZERO, UOP_EXEC_IF_SET);
          PC_W'(2): data <= mk_uop(OPCODE_ADD, UOP_DST_T2, UOP_SRC_T0, UOP_SRC_T1,   UOP_EXEC_ALWAYS);
          default:  data <= WORD_RDY;
        endcase
      end
      // Every word of the loop program is the same accumulate step; the
      // program deliberately has no RDY so it runs off the end of the PC.
      PROG_LOOP: data <= mk_uop(OPCODE_ADD, UOP_DST_T0, UOP_SRC_T0, UOP_SRC_ONE, UOP_EXEC_ALWAYS);
      default:   data <= WORD_RDY;
    endcase
  end

endmodule

// File: rtl/uop_prog_sequencer.sv
// Microprogram sequencer for the curve point engine.
// Fetches the selected program from uop_prog_sequencer_rom, filters each word
// by its exec condition against cond, and issues passing words to the
// datapath with a valid/ack handshake until an RDY opcode (done) or PC
// overflow (err).
// Ports: clk, rst (async, active-high), start/prog_sel (run request),
// cond (datapath condition), ready (idle), done/err (one-cycle pulses),
// uop_valid/uop_data/uop_ack (issue handshake).
module uop_prog_sequencer
  import uop_prog_sequencer_pkg::*;
#(
  parameter int UOP_W    = UOP_W_DEF,
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int EXEC_W   = EXEC_W_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int PROG_W   = PROG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PROG_W-1:0] prog_sel,
  input  logic              cond,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic              uop_valid,
  output logic [UOP_W-1:0]  uop_data,
  input  logic              uop_ack
);

  seq_state_e           state_r;
  logic [PC_W-1:0]      pc_r;
  logic [PROG_W-1:0]    prog_r;
  logic [UOP_W-1:0]     rom_data_s;
  logic [OPCODE_W-1:0]  opcode_s;
  logic [EXEC_W-1:0]    exec_s;
  logic                 issue_s;
  logic                 pc_last_s;

  uop_prog_sequencer_rom #(
    .UOP_W  (UOP_W),
    .PC_W   (PC_W),
    .PROG_W (PROG_W)
  ) u_rom (
    .clk  (clk),
    .addr ({prog_r, pc_r}),
    .data (rom_data_s)
  );

  assign opcode_s  = rom_data_s[UOP_W-1 -: OPCODE_W];
  assign exec_s    = rom_data_s[EXEC_W-1:0];
  assign issue_s   = exec_pass(exec_s, cond);
  assign pc_last_s = &pc_r;

  // Sequencer FSM with pc counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pc_r      <= {PC_W{1'b0}};
      prog_r    <= {PROG_W{1'b0}};
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      uop_valid <= 1'b0;
      uop_data  <= {UOP_W{1'b0}};
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            prog_r  <= prog_sel;
            pc_r    <= {PC_W{1'b0}};
            ready   <= 1'b0;
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: state_r <= ST_WAIT;
        ST_WAIT:  state_r <= ST_DECODE;
        ST_DECODE: begin
          if (opcode_s == OPCODE_RDY) begin
            done    <= 1'b1;
            ready   <= 1'b1;
            state_r <= ST_IDLE;
          end else if (issue_s) begin
            uop_data  <= rom_data_s;
            uop_valid <= 1'b1;
            state_r   <= ST_ISSUE;
          end else if (pc_last_s) begin
            // Skipping the final word: the program ran off the end.
            err     <= 1'b1;
            ready   <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            pc_r    <= pc_r + 1'b1;
            state_r <= ST_FETCH;
          end
        end
        ST_ISSUE: begin
          if (uop_ack) begin
            uop_valid <= 1'b0;
            if (pc_last_s) begin
              err     <= 1'b1;
              ready   <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              pc_r    <= pc_r + 1'b1;
              state_r <= ST_FETCH;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          ready     <= 1'b1;
          uop_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uop_prog_sequencer.sv
// Self-checking bench for uop_prog_sequencer. A reference model turns each
// program into an ordered list of expected events (issue / done / err) with
// the number of ROM words visited before each one; every visited word costs
// three cycles. Stimulus randomises cond, ack delay, idle gaps, stray start
// and ack pulses, and mid-run prog_sel changes.
module tb_uop_prog_sequencer;
  import uop_prog_sequencer_pkg::*;

  localparam int EV_ISSUE = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  prog_sel = 2'd0;
  logic        cond = 1'b0;
  logic        ready;
  logic        done;
  logic        err;
  logic        uop_valid;
  logic [19:0] uop_data;
  logic        uop_ack = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int          ev_kind[$];
  int          ev_w[$];
  logic [19:0] ev_word[$];

  always #5 clk = ~clk;

  uop_prog_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_sel  (prog_sel),
    .cond      (cond),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .uop_valid (uop_valid),
    .uop_data  (uop_data),
    .uop_ack   (uop_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] dst,
                                     input logic [3:0] sa, input logic [3:0] sb,
                                     input logic [1:0] ex);
    return {op, dst, sa, sb, 2'b00, ex};
  endfunction

  // Program contents as the engine's microcode listing describes them.
  function automatic logic [19:0] ref_word(input int prog, input int pc);
    logic [19:0] rdy;
    rdy = mk(OPCODE_RDY, 4'h0, 4'h0, 4'h0, UOP_EXEC_ALWAYS);
    if (prog == 0) begin
      if (pc == 0) return mk(OPCODE_MOV, UOP_DST_RX, UOP_SRC_GX,  UOP_SRC_ZERO, UOP_EXEC_ALWAYS);
      if (pc == 1) return mk(OPCODE_MOV, UOP_DST_RY, UOP_SRC_GY,  UOP_SRC_ZERO, UOP_EXEC_ALWAYS);
      if (pc == 2) return mk(OPCODE_MOV, UOP_DST_RZ, UOP_SRC_ONE, UOP_SRC_ZERO, UOP_EXEC_ALWAYS);
      return rdy;
    end
    if (prog == 1) begin
      if (pc == 0) return mk(OPCODE_MOV, UOP_DST_T0, UOP_SRC_GX, UOP_SRC_ZERO, UOP_EXEC_IF_CLR);
      if (pc == 1) return mk(OPCODE_MOV, UOP_DST_T1, UOP_SRC_GY, UOP_SRC_ZERO, UOP_EXEC_IF_SET);
      if (pc == 2) return mk(OPCODE_ADD, UOP_DST_T2, UOP_SRC_T0, UOP_SRC_T1,   UOP_EXEC_ALWAYS);
      return rdy;
    end
    if (prog == 3) return mk(OPCODE_ADD, UOP_DST_T0, UOP_SRC_T0, UOP_SRC_ONE, UOP_EXEC_ALWAYS);
    return rdy;
  endfunction

  function automatic bit ref_pass(input logic [1:0] ex, input bit c);
    return (ex == 2'b00) || (ex == 2'b01 && !c) || (ex == 2'b10 && c);
  endfunction

  // Expected event list for one run with cond held at c.
  task automatic build_model(input int prog, input bit c);
    int words;
    bit ended;
    logic [19:0] w;
    ev_kind.delete(); ev_w.delete(); ev_word.delete();
    words = 0;
    ended = 1'b0;
    for (int pc = 0; pc < 64; pc++) begin
      w = ref_word(prog, pc);
      words++;
      if (w[19:16] == OPCODE_RDY) begin
        ev_kind.push_back(EV_DONE); ev_w.push_back(words); ev_word.push_back(20'h0);
        ended = 1'b1;
        break;
      end
      if (ref_pass(w[1:0], c)) begin
        ev_kind.push_back(EV_ISSUE); ev_w.push_back(words); ev_word.push_back(w);
        words = 0;
      end
    end
    if (!ended) begin
      ev_kind.push_back(EV_ERR); ev_w.push_back(words); ev_word.push_back(20'h0);
    end
  endtask

  // One full run. chain=1 leaves start asserted-capable right at the done/err
  // cycle so the next run's start coincides with the completion pulse.
  task automatic run_prog(input int prog, input bit c, input int dmin, input int dmax, input bit chain);
    int cyc, last_ref, target, d;
    logic [19:0] word;
    build_model(prog, c);
    check_val("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1; prog_sel = 2'(prog); cond = c;
    @(posedge clk); #1;
    cyc = 0;
    start = 1'b0;
    prog_sel = 2'($urandom_range(0, 3));
    check_val("ready_after_start", 32'(ready), 32'd0);
    last_ref = 0;
    for (int i = 0; i < ev_kind.size(); i++) begin
      if (ev_kind[i] == EV_ERR && ev_w[i] == 0) continue;
      target = last_ref + 3 * ev_w[i];
      while (cyc < target) begin
        start   = 1'($urandom_range(0, 1));
        uop_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cyc++;
        start = 1'b0; uop_ack = 1'b0;
        if (cyc < target)
          check_val("busy_outputs", 32'({uop_valid, done, err, ready}), 32'd0);
      end
      if (ev_kind[i] == EV_ISSUE) begin
        word = ev_word[i];
        check_val("issue_valid", 32'({uop_valid, done, err, ready}), 32'b1000);
        check_val("issue_data", 32'(uop_data), 32'(word));
        d = $urandom_range(dmin, dmax);
        for (int k = 0; k < d; k++) begin
          start = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          cyc++;
          start = 1'b0;
          check_val("hold_valid", 32'({uop_valid, ready}), 32'b10);
          check_val("hold_data", 32'(uop_data), 32'(word));
        end
        uop_ack = 1'b1;
        @(posedge clk); #1;
        cyc++;
        uop_ack = 1'b0;
        check_val("ack_drop_valid", 32'(uop_valid), 32'd0);
        check_val("ack_keep_data", 32'(uop_data), 32'(word));
        last_ref = cyc;
        if (i + 1 < ev_kind.size() && ev_kind[i+1] == EV_ERR && ev_w[i+1] == 0)
          check_val("err_after_ack", 32'({done, err, ready}), 32'b011);
        else
          check_val("after_ack_busy", 32'({done, err, ready}), 32'b000);
      end else if (ev_kind[i] == EV_DONE) begin
        check_val("done_pulse", 32'({uop_valid, done, err, ready}), 32'b0101);
      end else begin
        check_val("err_pulse", 32'({uop_valid, done, err, ready}), 32'b0011);
      end
    end
    if (!chain) begin
      @(posedge clk); #1;
      check_val("pulse_cleared", 32'({uop_valid, done, err, ready}), 32'b0001);
    end
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(ready), 32'd1);
    check_val("rst_outs", 32'({done, err, uop_valid}), 32'd0);
    check_val("rst_data", 32'(uop_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("idle_ready", 32'(ready), 32'd1);

    run_prog(0, 1'($urandom_range(0, 1)), 0, 0, 1'b0);  // init, ack right away
    run_prog(2, 1'($urandom_range(0, 1)), 0, 0, 1'b0);  // empty program
    run_prog(1, 1'b1, 0, 3, 1'b0);                      // B, C
    run_prog(1, 1'b0, 0, 3, 1'b0);                      // A, C
    run_prog(0, 1'b0, 10, 10, 1'b0);                    // long ack hold
    run_prog(3, 1'b0, 0, 2, 1'b0);                      // PC overflow
    run_prog(2, 1'b1, 0, 0, 1'b1);                      // start on done cycle
    run_prog(1, 1'b1, 0, 1, 1'b1);
    run_prog(0, 1'b0, 0, 1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) begin
        uop_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        uop_ack = 1'b0;
      end
      run_prog($urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 4, 1'($urandom_range(0, 1)));
    end
    run_prog(3, 1'b1, 0, 0, 1'b0);

    // Asynchronous reset while a uop is outstanding.
    start = 1'b1; prog_sel = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (uop_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_val("pre_rst_valid", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_valid", 32'(uop_valid), 32'd0);
    check_val("async_rst_ready", 32'({ready, done, err}), 32'b100);
    check_val("async_rst_data", 32'(uop_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_idle", 32'({uop_valid, done, err, ready}), 32'b0001);
    run_prog(0, 1'b0, 0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
